// File: rtl/present_key_scheduler_pkg.sv
// Shared types and constants for the PRESENT-80 key schedule.
// Latency: none (declarations and a combinational helper only).
// Backpressure: not applicable.
package present_pkg;

  localparam int KEY_W      = 80;
  localparam int RK_W       = 64;
  localparam int RC_W       = 5;
  localparam int NUM_ROUNDS = 31;

  typedef enum logic {IDLE, RUN} ks_state_t;

  typedef logic [KEY_W-1:0] key_t;

  // PRESENT 4-bit S-box, shared by the cipher and the key schedule.
  function automatic logic [3:0] present_sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/present_key_scheduler_key_update.sv
// One PRESENT-80 key register update: rotate left 61, S-box top nibble, XOR round counter.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when to register the result.
module key_update
  import present_pkg::*;
(
  input  key_t              key,
  input  logic [RC_W-1:0]   round_ctr,
  output key_t              next_key
);

  key_t rot;

  // Rotate left by 61 (== right by 19), then apply the nonlinear and counter steps.
  always_comb begin
    rot                = {key[18:0], key[79:19]};
    next_key           = rot;
    next_key[79:76]    = present_sbox(rot[79:76]);
    next_key[19:15]    = rot[19:15] ^ round_ctr;
  end

endmodule

// File: rtl/present_key_scheduler.sv
// Sequential PRESENT-80 key schedule: takes an 80-bit key, streams round keys K1..K32.
// Latency: K1 valid the cycle after key accept; each next key the cycle after a handshake.
// Backpressure: rk_ready_i low holds rk_o/rk_idx_o and the key register; keys only accepted in IDLE.
module present_key_scheduler
  import present_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic [KEY_W-1:0]  key_i,
  input  logic              key_valid_i,
  output logic              key_ready_o,
  output logic [RK_W-1:0]   rk_o,
  output logic [5:0]        rk_idx_o,
  output logic              rk_valid_o,
  input  logic              rk_ready_i,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [5:0] LAST_IDX = 6'(NUM_ROUNDS + 1);

  ks_state_t  state, state_nxt;
  key_t       key_reg, key_nxt, key_upd;
  logic [5:0] round_ctr, ctr_nxt;
  logic       done_q, done_nxt;

  key_update u_key_update (
    .key       (key_reg),
    .round_ctr (round_ctr[RC_W-1:0]),
    .next_key  (key_upd)
  );

  // State, key register, counter and done pulse; async reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      key_reg   <= '0;
      round_ctr <= '0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      key_reg   <= key_nxt;
      round_ctr <= ctr_nxt;
      done_q    <= done_nxt;
    end
  end

  // Next-state, stream handshakes and abort handling; clear_i overrides any handshake.
  always_comb begin
    state_nxt   = state;
    key_nxt     = key_reg;
    ctr_nxt     = round_ctr;
    done_nxt    = 1'b0;
    key_ready_o = (state == IDLE);
    rk_valid_o  = (state == RUN);
    busy_o      = (state == RUN);

    if (clear_i) begin
      // key_reg is deliberately left alone so the last key stays observable.
      state_nxt = IDLE;
      ctr_nxt   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (key_valid_i) begin
            key_nxt   = key_i;
            ctr_nxt   = 6'd1;
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (rk_ready_i) begin
            if (round_ctr == LAST_IDX) begin
              // Final key consumed: no further update, index parks at 0 in IDLE.
              state_nxt = IDLE;
              ctr_nxt   = '0;
              done_nxt  = 1'b1;
            end else begin
              key_nxt = key_upd;
              ctr_nxt = round_ctr + 6'd1;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          ctr_nxt   = '0;
        end
      endcase
    end
  end

  assign rk_o     = key_reg[79:16];
  assign rk_idx_o = round_ctr;
  assign done_o   = done_q;

endmodule

// File: tb/tb_present_key_scheduler.sv
module tb_present_key_scheduler;

  logic        clk;
  logic        rst_n;
  logic        clear_i;
  logic [79:0] key_i;
  logic        key_valid_i;
  logic        key_ready_o;
  logic [63:0] rk_o;
  logic [5:0]  rk_idx_o;
  logic        rk_valid_o;
  logic        rk_ready_i;
  logic        busy_o;
  logic        done_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_rk [1:32];
  logic [63:0] got_rk [1:32];

  present_key_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (clear_i),
    .key_i       (key_i),
    .key_valid_i (key_valid_i),
    .key_ready_o (key_ready_o),
    .rk_o        (rk_o),
    .rk_idx_o    (rk_idx_o),
    .rk_valid_o  (rk_valid_o),
    .rk_ready_i  (rk_ready_i),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference S-box as a nibble table, S(15)..S(0).
  function automatic logic [3:0] sb(input logic [3:0] x);
    logic [63:0] tbl;
    tbl = 64'h21748FE3DA09B65C;
    return tbl[x*4 +: 4];
  endfunction

  function automatic logic [79:0] mdl_update(input logic [79:0] k, input logic [4:0] rc);
    logic [79:0] r;
    for (int i = 0; i < 80; i++) r[(i + 61) % 80] = k[i];
    r[79:76] = sb(r[79:76]);
    r[19:15] = r[19:15] ^ rc;
    return r;
  endfunction

  task automatic build_model(input logic [79:0] k);
    logic [79:0] kr;
    kr = k;
    for (int i = 1; i <= 32; i++) begin
      exp_rk[i] = kr[79:16];
      if (i < 32) kr = mdl_update(kr, 5'(i));
    end
  endtask

  function automatic logic [63:0] cipher(input logic [63:0] pt);
    logic [63:0] s, t;
    s = pt;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ got_rk[r];
      for (int n = 0; n < 16; n++) t[n*4 +: 4] = sb(s[n*4 +: 4]);
      for (int i = 0; i < 63; i++) s[(i * 16) % 63] = t[i];
      s[63] = t[63];
    end
    return s ^ got_rk[32];
  endfunction

  task automatic load_key(input logic [79:0] k);
    @(negedge clk);
    rk_ready_i  = 1'b0;
    check("ready_idle", key_ready_o, 1);
    key_i       = k;
    key_valid_i = 1'b1;
    @(posedge clk);
    #1;
    key_valid_i = 1'b0;
    key_i       = '0;
  endtask

  // Drain a schedule, checking index, key, stall holding and done timing.
  task automatic collect(input bit stall, input bit poke, output int done_cyc);
    int          nxt;
    bit          seen;
    bit          stalled;
    logic [63:0] hold_rk;
    logic [5:0]  hold_idx;
    nxt = 1; seen = 0; stalled = 0; done_cyc = -1;
    hold_rk = '0; hold_idx = '0;
    for (int cyc = 1; cyc <= 400 && !seen; cyc++) begin
      @(negedge clk);
      if (done_o) begin
        seen        = 1;
        done_cyc    = cyc;
        key_valid_i = 1'b0;
        rk_ready_i  = 1'b0;
        check("done_vs_valid", rk_valid_o, 0);
        check("done_after_k32", nxt, 33);
      end else begin
        if (stalled) begin
          check("hold_rk", rk_o, hold_rk);
          check("hold_idx", rk_idx_o, hold_idx);
        end
        check("rk_valid", rk_valid_o, 1);
        check("busy", busy_o, 1);
        check("rk_idx", rk_idx_o, nxt);
        if (nxt <= 32) check("rk", rk_o, exp_rk[nxt]);
        if (poke) begin
          key_valid_i = 1'b1;
          key_i       = 80'hDEAD_BEEF_0BAD_F00D_1234;
          check("ready_busy", key_ready_o, 0);
        end
        rk_ready_i = stall ? 1'($urandom_range(0, 1)) : 1'b1;
        stalled    = !rk_ready_i;
        hold_rk    = rk_o;
        hold_idx   = rk_idx_o;
        if (rk_ready_i) begin
          if (nxt <= 32) got_rk[nxt] = rk_o;
          nxt++;
        end
      end
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  task automatic run_to(input int idx);
    bit hit;
    hit = 0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(negedge clk);
      if (rk_valid_o && rk_idx_o == 6'(idx)) hit = 1;
      else rk_ready_i = 1'b1;
    end
    if (!hit) check("run_to_timeout", 0, 1);
  endtask

  initial begin
    int d;
    rst_n = 1'b0; clear_i = 1'b0; key_i = '0; key_valid_i = 1'b0; rk_ready_i = 1'b0;
    #12;
    check("rst_ready", key_ready_o, 1);
    check("rst_valid", rk_valid_o, 0);
    check("rst_rk", rk_o, 0);
    check("rst_idx", rk_idx_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_done", done_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: all-zero key, no stalls.
    build_model(80'h0);
    check("model_k2_zero", exp_rk[2], 64'hC000000000000000);
    load_key(80'h0);
    collect(0, 0, d);
    check("t1_k1", got_rk[1], 64'h0000000000000000);
    check("t1_k2", got_rk[2], 64'hC000000000000000);
    check("t1_k32", got_rk[32], exp_rk[32]);
    check("t1_done_cyc", d, 33);
    @(negedge clk);
    check("t1_idle_after_done", done_o, 0);

    // 2: all-ones key, back-to-back; full cipher on all-ones plaintext.
    build_model({80{1'b1}});
    load_key({80{1'b1}});
    collect(0, 0, d);
    check("t2_k1", got_rk[1], 64'hFFFFFFFFFFFFFFFF);
    check("t2_cipher", cipher({64{1'b1}}), 64'h3333DCD3213210D2);

    // 3: random backpressure.
    build_model(80'h0123_4567_89AB_CDEF_0123);
    load_key(80'h0123_4567_89AB_CDEF_0123);
    collect(1, 0, d);
    check("t3_k32", got_rk[32], exp_rk[32]);

    // 4: key offers during RUN are ignored.
    build_model(80'hA5A5_5A5A_F0F0_0F0F_3C3C);
    load_key(80'hA5A5_5A5A_F0F0_0F0F_3C3C);
    collect(0, 1, d);
    check("t4_k32", got_rk[32], exp_rk[32]);
    check("t4_done_cyc", d, 33);

    // 5: clear at index 10, with a coincident rk handshake.
    build_model(80'h1357_9BDF_2468_ACE0_FFFF);
    load_key(80'h1357_9BDF_2468_ACE0_FFFF);
    run_to(10);
    clear_i = 1'b1; rk_ready_i = 1'b1;
    @(negedge clk);
    clear_i = 1'b0; rk_ready_i = 1'b0;
    check("t5_valid", rk_valid_o, 0);
    check("t5_done", done_o, 0);
    check("t5_idx", rk_idx_o, 0);
    check("t5_ready", key_ready_o, 1);
    check("t5_key_kept", rk_o, exp_rk[10]);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5_no_done", done_o, 0);
    end
    // Key offered together with clear is discarded.
    key_i = 80'h1; key_valid_i = 1'b1; clear_i = 1'b1;
    @(negedge clk);
    key_valid_i = 1'b0; clear_i = 1'b0;
    check("t5_clr_key_busy", busy_o, 0);
    build_model(80'hFEDC_BA98_7654_3210_0000);
    load_key(80'hFEDC_BA98_7654_3210_0000);
    collect(0, 0, d);
    check("t5_restart_k1", got_rk[1], 64'hFEDCBA9876543210);

    // 6: async reset mid-run at index 20.
    build_model(80'h0F1E_2D3C_4B5A_6978_8796);
    load_key(80'h0F1E_2D3C_4B5A_6978_8796);
    run_to(20);
    rk_ready_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t6_valid", rk_valid_o, 0);
    check("t6_rk", rk_o, 0);
    check("t6_idx", rk_idx_o, 0);
    check("t6_ready", key_ready_o, 1);
    check("t6_busy", busy_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_no_stale_valid", rk_valid_o, 0);
      check("t6_ready_after", key_ready_o, 1);
    end
    load_key(80'h0F1E_2D3C_4B5A_6978_8796);
    collect(1, 0, d);
    check("t6_k32", got_rk[32], exp_rk[32]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
